// File: rtl/gear_shift_ctrl.sv
// rtl/gear_shift_ctrl.sv - debounced P/R/N/D/D-low shift controller with brake and standstill interlocks
module gear_shift_ctrl #(
  parameter int DEBOUNCE_MS = 20,
  parameter int STOP_SPEED  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1ms,
  input  logic       engine_on,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_low,
  input  logic       sw_side_brake,
  input  logic       is_brake_normal,
  input  logic       is_brake_hard,
  input  logic [7:0] speed,
  output logic [3:0] current_gear,
  output logic       is_low_gear_mode,
  output logic [2:0] max_gear_limit,
  output logic       is_side_brake,
  output logic       shift_denied
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  typedef enum logic [2:0] {ST_PARK, ST_REV, ST_NEU, ST_DRV, ST_DLOW} state_t;

  // bit order: 0 up, 1 down, 2 low, 3 side brake
  logic [3:0]    raw, sync1, sync2, deb, flip;
  logic [CW-1:0] cnt [4];
  logic [2:0]    btn_ev;

  assign raw = {sw_side_brake, btn_low, btn_down, btn_up};

  always_comb begin
    for (int i = 0; i < 4; i++)
      flip[i] = tick_1ms && (sync2[i] != deb[i]) && (cnt[i] == CW'(DEBOUNCE_MS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      btn_ev <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      deb    <= deb ^ flip;
      btn_ev <= flip[2:0] & sync2[2:0];
      if (tick_1ms) begin
        for (int i = 0; i < 4; i++)
          cnt[i] <= ((sync2[i] != deb[i]) && !flip[i]) ? cnt[i] + 1'b1 : '0;
      end
    end
  end

  logic   up_ev, dn_ev, low_ev, brake, stopped;
  state_t state, state_n;
  logic [2:0] lim, lim_n;
  logic   deny_n, deny_q;

  assign up_ev   = btn_ev[0];
  assign dn_ev   = btn_ev[1];
  assign low_ev  = btn_ev[2];
  assign brake   = is_brake_normal | is_brake_hard;
  assign stopped = speed <= 8'(STOP_SPEED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_PARK;
      lim    <= 3'd6;
      deny_q <= 1'b0;
    end else begin
      state  <= state_n;
      lim    <= lim_n;
      deny_q <= deny_n;
    end
  end

  always_comb begin
    state_n = state;
    lim_n   = lim;
    deny_n  = 1'b0;
    if (!engine_on) begin
      deny_n = up_ev | dn_ev | low_ev;
      if (stopped && state != ST_PARK) state_n = ST_PARK;
    end else if (low_ev) begin
      case (state)
        ST_DRV: begin
          state_n = ST_DLOW;
          lim_n   = (speed < 8'd30) ? 3'd1 : (speed < 8'd60) ? 3'd2 : 3'd3;
        end
        ST_DLOW: state_n = ST_DRV;
        default: deny_n = 1'b1;
      endcase
    end else if (up_ev && dn_ev) begin
      deny_n = 1'b1;
    end else if (up_ev) begin
      case (state)
        ST_PARK: if (brake && stopped) state_n = ST_REV; else deny_n = 1'b1;
        ST_REV:  state_n = ST_NEU;
        ST_NEU:  state_n = ST_DRV;
        ST_DLOW: if (lim >= 3'd3) deny_n = 1'b1; else lim_n = lim + 3'd1;
        default: deny_n = 1'b1;
      endcase
    end else if (dn_ev) begin
      case (state)
        ST_REV:  if (stopped) state_n = ST_PARK; else deny_n = 1'b1;
        ST_NEU:  if (stopped && brake) state_n = ST_REV; else deny_n = 1'b1;
        ST_DRV:  state_n = ST_NEU;
        ST_DLOW: if (lim <= 3'd1) deny_n = 1'b1; else lim_n = lim - 3'd1;
        default: deny_n = 1'b1;
      endcase
    end
    // the limit only has meaning in D-low; every other state shows the full range
    if (state_n != ST_DLOW) lim_n = 3'd6;
  end

  always_comb begin
    case (state)
      ST_PARK: current_gear = 4'd3;
      ST_REV:  current_gear = 4'd6;
      ST_NEU:  current_gear = 4'd9;
      ST_DRV:  current_gear = 4'd12;
      ST_DLOW: current_gear = 4'd12;
      default: current_gear = 4'd3;
    endcase
    is_low_gear_mode = (state == ST_DLOW);
    max_gear_limit   = lim;
    is_side_brake    = deb[3];
    shift_denied     = deny_q;
  end

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// tb/tb_gear_shift_ctrl.sv - randomized self-checking bench for gear_shift_ctrl
module tb_gear_shift_ctrl;

  localparam int DEB = 20;

  logic       clk = 1'b0;
  logic       rst, tick_1ms, engine_on, btn_up, btn_down, btn_low, sw_side_brake;
  logic       is_brake_normal, is_brake_hard;
  logic [7:0] speed;
  logic [3:0] current_gear;
  logic       is_low_gear_mode, is_side_brake, shift_denied;
  logic [2:0] max_gear_limit;

  gear_shift_ctrl #(.DEBOUNCE_MS(DEB), .STOP_SPEED(0)) dut (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .engine_on(engine_on),
    .btn_up(btn_up), .btn_down(btn_down), .btn_low(btn_low),
    .sw_side_brake(sw_side_brake), .is_brake_normal(is_brake_normal),
    .is_brake_hard(is_brake_hard), .speed(speed), .current_gear(current_gear),
    .is_low_gear_mode(is_low_gear_mode), .max_gear_limit(max_gear_limit),
    .is_side_brake(is_side_brake), .shift_denied(shift_denied)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference: gear index 0..3 = P,R,N,D; code = 3*(index+1)
  int m_gear = 0;
  int m_lim = 6;
  bit m_low = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick_1ms = 1'b1;
    step();
    tick_1ms = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_gear"}, 32'(current_gear), 32'(3 * (m_gear + 1)));
    check({tag, "_low"}, 32'(is_low_gear_mode), 32'(m_low));
    check({tag, "_lim"}, 32'(max_gear_limit), 32'(m_low ? m_lim : 6));
  endtask

  function automatic bit model_apply(bit u, bit d, bit l);
    bit brk = is_brake_normal || is_brake_hard;
    bit stp = (speed == 8'd0);
    if (!engine_on) return 1'b1;
    if (l) begin
      if (m_gear != 3) return 1'b1;
      if (!m_low) begin
        m_low = 1'b1;
        m_lim = (speed < 30) ? 1 : ((speed < 60) ? 2 : 3);
      end else begin
        m_low = 1'b0;
        m_lim = 6;
      end
      return 1'b0;
    end
    if (u && d) return 1'b1;
    if (u) begin
      if (m_gear == 3) begin
        if (!m_low || m_lim == 3) return 1'b1;
        m_lim++;
        return 1'b0;
      end
      if (m_gear == 0 && !(brk && stp)) return 1'b1;
      m_gear++;
      return 1'b0;
    end
    if (d) begin
      if (m_gear == 3 && m_low) begin
        if (m_lim == 1) return 1'b1;
        m_lim--;
        return 1'b0;
      end
      if (m_gear == 0) return 1'b1;
      if (m_gear == 1 && !stp) return 1'b1;
      if (m_gear == 2 && !(stp && brk)) return 1'b1;
      m_gear--;
      return 1'b0;
    end
    return 1'b0;
  endfunction

  task automatic settle(input string tag);
    step();
    if (!engine_on && speed == 8'd0 && m_gear != 0) begin
      m_gear = 0;
      m_low  = 1'b0;
      m_lim  = 6;
    end
    check_state(tag);
    check({tag, "_den"}, 32'(shift_denied), 32'd0);
  endtask

  // hold the chosen buttons for nt ticks, check the response, then release and re-debounce
  task automatic press(input string tag, input bit u, input bit d, input bit l, input int nt);
    bit exp_den;
    int old_code;
    btn_up = u; btn_down = d; btn_low = l;
    repeat (3) step();
    for (int k = 0; k < nt; k++) do_tick();
    old_code = 3 * (m_gear + 1);
    if (nt >= DEB) begin
      check({tag, "_early"}, 32'(current_gear), 32'(old_code));
      check({tag, "_early_den"}, 32'(shift_denied), 32'd0);
      exp_den = model_apply(u, d, l);
      step();
      check_state(tag);
      check({tag, "_den"}, 32'(shift_denied), 32'(exp_den));
      step();
      check({tag, "_den_off"}, 32'(shift_denied), 32'd0);
    end else begin
      step();
      step();
      check_state({tag, "_short"});
      check({tag, "_short_den"}, 32'(shift_denied), 32'd0);
    end
    btn_up = 1'b0; btn_down = 1'b0; btn_low = 1'b0;
    repeat (3) step();
    for (int k = 0; k < DEB; k++) do_tick();
    step();
    step();
    check_state({tag, "_rel"});
    check({tag, "_rel_den"}, 32'(shift_denied), 32'd0);
  endtask

  task automatic set_cond(input bit eng, input bit bn, input bit bh, input int spd);
    engine_on = eng; is_brake_normal = bn; is_brake_hard = bh; speed = 8'(spd);
  endtask

  initial begin
    rst = 1'b1; tick_1ms = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_low = 1'b0;
    sw_side_brake = 1'b0;
    set_cond(1, 1, 0, 0);
    repeat (3) step();
    check("rst_gear", 32'(current_gear), 32'd3);
    check("rst_low", 32'(is_low_gear_mode), 32'd0);
    check("rst_lim", 32'(max_gear_limit), 32'd6);
    check("rst_sb", 32'(is_side_brake), 32'd0);
    check("rst_den", 32'(shift_denied), 32'd0);
    rst = 1'b0;
    step();

    sw_side_brake = 1'b1;
    repeat (3) step();
    for (int k = 0; k < DEB - 1; k++) do_tick();
    check("sb_19", 32'(is_side_brake), 32'd0);
    do_tick();
    check("sb_20", 32'(is_side_brake), 32'd1);

    press("dbnc19", 1, 0, 0, DEB - 1);
    check("dbnc19_gear", 32'(current_gear), 32'd3);
    press("dbnc20", 1, 0, 0, DEB);
    check("dbnc20_gear", 32'(current_gear), 32'd6);
    press("back_p", 0, 1, 0, DEB);

    set_cond(1, 0, 0, 0);
    press("park_nobrk", 1, 0, 0, DEB);
    check("park_nobrk_gear", 32'(current_gear), 32'd3);
    set_cond(1, 0, 1, 0);
    press("park_hard", 1, 0, 0, DEB);
    check("park_hard_gear", 32'(current_gear), 32'd6);

    press("seq_n", 1, 0, 0, DEB);
    press("seq_d", 1, 0, 0, DEB);
    check("seq_d_gear", 32'(current_gear), 32'd12);
    set_cond(1, 0, 1, 40);
    press("seq_dn1", 0, 1, 0, DEB);
    check("seq_dn1_gear", 32'(current_gear), 32'd9);
    press("seq_dn2", 0, 1, 0, DEB);
    check("seq_dn2_gear", 32'(current_gear), 32'd9);
    press("seq_up", 1, 0, 0, DEB);

    set_cond(1, 0, 0, 45);
    press("low_in", 0, 0, 1, DEB);
    check("low_in_lim", 32'(max_gear_limit), 32'd2);
    press("low_up1", 1, 0, 0, DEB);
    press("low_up2", 1, 0, 0, DEB);
    check("low_up2_lim", 32'(max_gear_limit), 32'd3);
    press("low_dn", 0, 1, 0, DEB);
    press("low_out", 0, 0, 1, DEB);
    check("low_out_lim", 32'(max_gear_limit), 32'd6);

    set_cond(0, 0, 0, 0);
    settle("eng_off0");
    check("eng_off0_gear", 32'(current_gear), 32'd3);
    set_cond(1, 1, 0, 0);
    press("re_r", 1, 0, 0, DEB);
    press("re_n", 1, 0, 0, DEB);
    press("re_d", 1, 0, 0, DEB);
    set_cond(0, 1, 0, 30);
    settle("eng_off30");
    press("eng_off30_dn", 0, 1, 0, DEB);
    check("eng_off30_gear", 32'(current_gear), 32'd12);

    set_cond(1, 1, 0, 0);
    sw_side_brake = 1'b0;
    btn_up = 1'b1;
    repeat (3) step();
    for (int k = 0; k < 10; k++) do_tick();
    rst = 1'b1;
    step();
    check("mid_rst_gear", 32'(current_gear), 32'd3);
    check("mid_rst_low", 32'(is_low_gear_mode), 32'd0);
    check("mid_rst_lim", 32'(max_gear_limit), 32'd6);
    check("mid_rst_sb", 32'(is_side_brake), 32'd0);
    check("mid_rst_den", 32'(shift_denied), 32'd0);
    rst = 1'b0;
    m_gear = 0; m_low = 1'b0; m_lim = 6;
    press("post_rst", 1, 0, 0, DEB);
    check("post_rst_gear", 32'(current_gear), 32'd6);

    for (int it = 0; it < 60; it++) begin
      int act;
      set_cond($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) == 0,
               ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 90)));
      settle("rnd_set");
      act = int'($urandom_range(0, 6));
      case (act)
        0, 1: press("rnd_up", 1, 0, 0, DEB);
        2:    press("rnd_dn", 0, 1, 0, DEB);
        3:    press("rnd_low", 0, 0, 1, DEB);
        4:    press("rnd_updn", 1, 1, 0, DEB);
        5:    press("rnd_lowx", $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 1, 1, DEB);
        default: press("rnd_part", 1, 0, 0, int'($urandom_range(1, DEB - 1)));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
